// File: rtl/calc_cmd_sequencer.sv
// Calculator command sequencer: queues host commands and runs them one at a time
// against the divider config, memory write port and ALU->serializer. Optional ALU watchdog: CALC_SEQ_TIMEOUT_EN.
module calc_cmd_sequencer #(
    parameter int INBITS = 8,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                InputKey,
    input  logic                ValidCmd,
    input  logic                RW,
    input  logic                ConfigDiv,
    input  logic [3:0]          Sel,
    input  logic [31:0]         Din,
    input  logic [WIDTH-1:0]    Addr,
    input  logic [INBITS-1:0]   InA,
    input  logic [INBITS-1:0]   InB,
    output logic [7:0]          DivCfg,
    output logic                DivCfgLoad,
    output logic                MemWe,
    output logic [WIDTH-1:0]    MemAddr,
    output logic [31:0]         MemWdata,
    output logic                AluStart,
    output logic [3:0]          AluSel,
    output logic [INBITS-1:0]   AluA,
    output logic [INBITS-1:0]   AluB,
    input  logic                AluDone,
    input  logic [2*INBITS-1:0] AluResult,
    input  logic                SerBusy,
    output logic                SerStart,
    output logic [2*INBITS-1:0] SerData,
    output logic                CalcBusy,
    output logic                CmdDrop,
    output logic                SeqErr
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {T_CALC, T_WR, T_CFG} cmd_type_e;
    typedef enum logic [2:0] {S_IDLE, S_CFG, S_WR, S_ALU, S_ALU_WAIT, S_SER} state_e;
    typedef struct packed {
        cmd_type_e         typ;
        logic [3:0]        sel;
        logic [WIDTH-1:0]  addr;
        logic [31:0]       din;
        logic [INBITS-1:0] a;
        logic [INBITS-1:0] b;
    } cmd_t;

    cmd_t                queue_mem [DEPTH];
    cmd_t                new_cmd, head;
    logic [PW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                q_empty, q_full, push, pop;
    state_e              state_q, state_d;
    logic [7:0]          cfg_val_q, cfg_val_d;
    logic [7:0]          div_cfg_q, div_cfg_d;
    logic                div_load_q, div_load_d;
    logic                mem_we_q, mem_we_d;
    logic [WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                alu_start_q, alu_start_d;
    logic [3:0]          alu_sel_q, alu_sel_d;
    logic [INBITS-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic                ser_start_q, ser_start_d;
    logic [2*INBITS-1:0] ser_data_q, ser_data_d;
    logic                calc_busy_q, calc_busy_d;
    logic                cmd_drop_q, cmd_drop_d;
`ifdef CALC_SEQ_TIMEOUT_EN
    logic [7:0]          wdog_q, wdog_d;
    logic                seq_err_q, seq_err_d;
`endif

    always_comb begin
        new_cmd.typ  = ConfigDiv ? T_CFG : (RW ? T_WR : T_CALC);
        new_cmd.sel  = Sel;
        new_cmd.addr = Addr;
        new_cmd.din  = Din;
        new_cmd.a    = InA;
        new_cmd.b    = InB;
    end

    // Full is judged on the registered pointers, so a same-cycle pop never frees room.
    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push    = ValidCmd && InputKey && !q_full;
    assign pop     = (state_q == S_IDLE) && !q_empty;
    assign head    = queue_mem[rd_ptr_q[PW-1:0]];
    assign wr_ptr_d = push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;

    always_ff @(posedge Clk) begin
        if (push) queue_mem[wr_ptr_q[PW-1:0]] <= new_cmd;
    end

    always_comb begin
        state_d     = state_q;
        cfg_val_d   = cfg_val_q;
        div_cfg_d   = div_cfg_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        ser_data_d  = ser_data_q;
        div_load_d  = 1'b0;
        mem_we_d    = 1'b0;
        alu_start_d = 1'b0;
        ser_start_d = 1'b0;
        cmd_drop_d  = ValidCmd && !push;
        calc_busy_d = !q_empty || (state_q != S_IDLE);
`ifdef CALC_SEQ_TIMEOUT_EN
        wdog_d      = wdog_q;
        seq_err_d   = seq_err_q;
`endif
        // Each action state lasts two cycles: arm the registered pulse, then leave while it is visible.
        case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    cfg_val_d   = head.din[7:0];
                    mem_addr_d  = head.addr;
                    mem_wdata_d = head.din;
                    alu_sel_d   = head.sel;
                    alu_a_d     = head.a;
                    alu_b_d     = head.b;
                    case (head.typ)
                        T_CFG:   state_d = S_CFG;
                        T_WR:    state_d = S_WR;
                        default: state_d = S_ALU;
                    endcase
                end
            end
            S_CFG: begin
                if (div_load_q) state_d = S_IDLE;
                else begin
                    div_cfg_d  = cfg_val_q;
                    div_load_d = 1'b1;
                end
            end
            S_WR: begin
                if (mem_we_q) state_d = S_IDLE;
                else          mem_we_d = 1'b1;
            end
            S_ALU: begin
`ifdef CALC_SEQ_TIMEOUT_EN
                wdog_d = 8'd0;
`endif
                if (alu_start_q) state_d = S_ALU_WAIT;
                else             alu_start_d = 1'b1;
            end
            S_ALU_WAIT: begin
                if (AluDone) begin
                    ser_data_d = AluResult;
                    state_d    = S_SER;
                end
`ifdef CALC_SEQ_TIMEOUT_EN
                else if (wdog_q == 8'd254) begin
                    seq_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            S_SER: begin
                if (ser_start_q)  state_d = S_IDLE;
                else if (!SerBusy) ser_start_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            cfg_val_q   <= '0;
            div_cfg_q   <= '0;
            div_load_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            alu_start_q <= 1'b0;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            ser_start_q <= 1'b0;
            ser_data_q  <= '0;
            calc_busy_q <= 1'b0;
            cmd_drop_q  <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
            wdog_q      <= '0;
            seq_err_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            cfg_val_q   <= cfg_val_d;
            div_cfg_q   <= div_cfg_d;
            div_load_q  <= div_load_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            alu_start_q <= alu_start_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            ser_start_q <= ser_start_d;
            ser_data_q  <= ser_data_d;
            calc_busy_q <= calc_busy_d;
            cmd_drop_q  <= cmd_drop_d;
`ifdef CALC_SEQ_TIMEOUT_EN
            wdog_q      <= wdog_d;
            seq_err_q   <= seq_err_d;
`endif
        end
    end

    assign DivCfg     = div_cfg_q;
    assign DivCfgLoad = div_load_q;
    assign MemWe      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemWdata   = mem_wdata_q;
    assign AluStart   = alu_start_q;
    assign AluSel     = alu_sel_q;
    assign AluA       = alu_a_q;
    assign AluB       = alu_b_q;
    assign SerStart   = ser_start_q;
    assign SerData    = ser_data_q;
    assign CalcBusy   = calc_busy_q;
    assign CmdDrop    = cmd_drop_q;
`ifdef CALC_SEQ_TIMEOUT_EN
    assign SeqErr     = seq_err_q;
`else
    assign SeqErr     = 1'b0;
`endif
endmodule
